// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : RV32I instruction fetch stage. Holds the PC, issues ready-
//               handshaked requests to the instruction cache and owns the
//               IF/ID pipeline register. It absorbs cache wait states,
//               decode stalls (one-entry skid buffer) and branch redirects
//               (DROP state keeps an outstanding request address stable).
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_ready_i,
  input  logic [31:0] icache_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        fetch_busy_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic [31:0] w_target;
  logic [31:0] w_addr;

  assign w_target = {redirect_pc_i[31:2], 2'b00};

  // State, PC, skid buffer and IF/ID register; reset clears without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      drop_addr_q   <= 32'h0;
      buf_inst_q    <= 32'h0;
      buf_pc_q      <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_inst_q  <= NOP_INST;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_addr_q   <= drop_addr_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_q      <= buf_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
    end
  end

  // Next-state, request outputs and IF/ID update; a redirect always wins
  // and flushes IF/ID to a bubble regardless of stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    icache_req_o  = 1'b1;
    w_addr        = pc_q;

    case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          pc_d = w_target;
          if (!icache_ready_i) begin
            // Request already presented must stay stable until accepted.
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (icache_ready_i) begin
          pc_d = pc_q + 32'd4;
          if (!stall_i) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_inst_d  = icache_data_i;
          end else begin
            // Decoder busy: park the returned word so nothing is lost.
            buf_pc_d   = pc_q;
            buf_inst_d = icache_data_i;
            state_d    = S_HOLD;
          end
        end else if (!stall_i) begin
          if_id_valid_d = 1'b0;
          if_id_inst_d  = NOP_INST;
        end
      end

      S_HOLD: begin
        icache_req_o = 1'b0;
        if (redirect_i) begin
          pc_d    = w_target;
          state_d = S_REQ;
        end else if (!stall_i) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = buf_pc_q;
          if_id_inst_d  = buf_inst_q;
          state_d       = S_REQ;
        end
      end

      S_DROP: begin
        w_addr = drop_addr_q;
        if (redirect_i) begin
          pc_d = w_target;
        end
        if (icache_ready_i) begin
          state_d = S_REQ;
        end
        if (!stall_i) begin
          if_id_valid_d = 1'b0;
          if_id_inst_d  = NOP_INST;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redirect_i) begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
    end
  end

  assign icache_addr_o = {w_addr[31:2], 2'b00};
  assign if_id_valid_o = if_id_valid_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_inst_o  = if_id_inst_q;
  assign fetch_busy_o  = (state_q != S_REQ);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. A cache model returns a
//               word derived from the address; expected IF/ID contents are
//               queued as each cycle is driven and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        req, req2;
  logic [31:0] addr, addr2;
  logic [31:0] data, data2;
  logic        v, v2;
  logic [31:0] ipc, ipc2;
  logic [31:0] inst, inst2;
  logic        busy, busy2;

  int n_vec;
  int n_err;
  exp_t sb[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign data  = ready ? mem(addr)  : 32'hDEAD_BEEF;
  assign data2 = ready ? mem(addr2) : 32'hDEAD_BEEF;

  if_stage u_dut (
    .clk(clk), .rst(rst),
    .icache_req_o(req), .icache_addr_o(addr),
    .icache_ready_i(ready), .icache_data_i(data),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .if_id_valid_o(v), .if_id_pc_o(ipc), .if_id_inst_o(inst),
    .fetch_busy_o(busy)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .icache_req_o(req2), .icache_addr_o(addr2),
    .icache_ready_i(ready), .icache_data_i(data2),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .if_id_valid_o(v2), .if_id_pc_o(ipc2), .if_id_inst_o(inst2),
    .fetch_busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive, check request side, queue IF/ID expectation, clock, compare.
  task automatic step(input logic rdy, input logic stl, input logic rd,
                      input logic [31:0] rpc, input logic e_req,
                      input logic [31:0] e_addr, input logic e_busy,
                      input logic e_v, input logic [31:0] e_pc,
                      input logic [31:0] e_inst);
    exp_t e;
    @(negedge clk);
    ready = rdy; stall = stl; redirect = rd; redirect_pc = rpc;
    #1;
    chk("icache_req", {31'h0, req}, {31'h0, e_req});
    if (e_req) chk("icache_addr", addr, e_addr);
    chk("fetch_busy", {31'h0, busy}, {31'h0, e_busy});
    e.v = e_v; e.pc = e_pc; e.inst = e_inst;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("if_id_valid", {31'h0, v}, {31'h0, e.v});
    chk("if_id_pc", ipc, e.pc);
    chk("if_id_inst", inst, e.inst);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #2;
    chk("rst_valid", {31'h0, v}, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", ipc, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h1);
    chk("rst_addr", addr, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait streaming; the wrap instance fetches FFFFFFFC then 0.
    step(1, 0, 0, 0, 1, 32'h0, 0, 1, 32'h0, mem(32'h0));
    chk("wrap_pc0", ipc2, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 1, 32'h4, 0, 1, 32'h4, mem(32'h4));
    chk("wrap_pc1", ipc2, 32'h0);
    chk("wrap_inst1", inst2, mem(32'h0));

    // Two wait states at 0x8: bubbles, address held.
    step(0, 0, 0, 0, 1, 32'h8, 0, 0, 32'h4, NOP);
    step(0, 0, 0, 0, 1, 32'h8, 0, 0, 32'h4, NOP);
    step(1, 0, 0, 0, 1, 32'h8, 0, 1, 32'h8, mem(32'h8));
    step(1, 0, 0, 0, 1, 32'hC, 0, 1, 32'hC, mem(32'hC));

    // Three stall cycles coinciding with ready at 0x10.
    step(1, 1, 0, 0, 1, 32'h10, 0, 1, 32'hC, mem(32'hC));
    step(0, 1, 0, 0, 0, 32'h0, 1, 1, 32'hC, mem(32'hC));
    step(0, 1, 0, 0, 0, 32'h0, 1, 1, 32'hC, mem(32'hC));
    step(0, 0, 0, 0, 0, 32'h0, 1, 1, 32'h10, mem(32'h10));
    step(1, 0, 0, 0, 1, 32'h14, 0, 1, 32'h14, mem(32'h14));
    step(1, 0, 0, 0, 1, 32'h18, 0, 1, 32'h18, mem(32'h18));
    step(1, 0, 0, 0, 1, 32'h1C, 0, 1, 32'h1C, mem(32'h1C));

    // Redirect to 0x103 while 0x20 is waiting: 0x20 held and dropped.
    step(0, 0, 1, 32'h103, 1, 32'h20, 0, 0, 32'h1C, NOP);
    step(0, 0, 0, 0, 1, 32'h20, 1, 0, 32'h1C, NOP);
    step(1, 0, 0, 0, 1, 32'h20, 1, 0, 32'h1C, NOP);
    step(1, 0, 0, 0, 1, 32'h100, 0, 1, 32'h100, mem(32'h100));

    // Redirect with stall and valid IF/ID flushes anyway.
    step(1, 1, 1, 32'h200, 1, 32'h104, 0, 0, 32'h100, NOP);
    step(1, 0, 0, 0, 1, 32'h200, 0, 1, 32'h200, mem(32'h200));

    // Redirect while parked in HOLD discards the buffered word.
    step(1, 1, 0, 0, 1, 32'h204, 0, 1, 32'h200, mem(32'h200));
    step(0, 1, 1, 32'h300, 0, 32'h0, 1, 0, 32'h200, NOP);
    step(1, 0, 0, 0, 1, 32'h300, 0, 1, 32'h300, mem(32'h300));

    // Second redirect while dropping only moves the PC.
    step(0, 0, 1, 32'h400, 1, 32'h304, 0, 0, 32'h300, NOP);
    step(0, 0, 1, 32'h500, 1, 32'h304, 1, 0, 32'h300, NOP);
    step(1, 0, 0, 0, 1, 32'h304, 1, 0, 32'h300, NOP);
    step(1, 0, 0, 0, 1, 32'h500, 0, 1, 32'h500, mem(32'h500));

    // Asynchronous reset mid-fetch.
    @(negedge clk);
    ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, v}, 32'h0);
    chk("arst_inst", inst, NOP);
    chk("arst_pc", ipc, 32'h0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_addr_wrap", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 1, 32'h0, 0, 1, 32'h0, mem(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
